twofish_round_stage: RTL and testbench
======================================

# twofish_round_stage

Registered Twofish encryption round: takes the 128-bit round state (R0..R3), two round subkeys and the S-box key words, and produces the next round state. It sits directly downstream of the key-dependent g function and consumes its output: two func_g instances, then PHT, subkey add, and the rotate/XOR/swap. Sixteen instances chained via valid/ready form the pipelined encryption core.

## Interface
Parameters:
- SWAP, 1: 1 = standard word swap at output; 0 = no swap, used by the final round before output whitening.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Asynchronous, active-high reset.
- in_valid  input  1  Upstream holds a valid round state.
- in_ready  output  1  Stage accepts the input this cycle.
- in_r0, in_r1, in_r2, in_r3  input  32 each  Round state words.
- in_k0, in_k1  input  32 each  Subkeys K(2r+8) and K(2r+9), sampled with the state.
- in_s0, in_s1  input  32 each  S-box key words for func_g, sampled with the state.
- out_valid  output  1  Output state valid.
- out_ready  input  1  Downstream accepts the output.
- out_r0, out_r1, out_r2, out_r3  output  32 each  Next round state.

## Operation
- Stage A (combinational into register A):
  - T0 = func_g(in_r0, in_s0, in_s1).
  - T1 = func_g(ROL(in_r1, 8), in_s0, in_s1).
  - Register A holds T0, T1, in_r0..in_r3 and in_k0/in_k1.
- Stage B (combinational into register B), all additions mod 2^32, carries discarded:
  - F0 = T0 + T1 + K0.
  - F1 = T0 + 2·T1 + K1.
  - N2 = ROR(R2 XOR F0, 1).
  - N3 = ROL(R3, 1) XOR F1.
- Output word mapping:
  - SWAP=1: out = {N2, N3, R0, R1}.
  - SWAP=0: out = {R0, R1, N2, N3}.
- ROL/ROR are 32-bit circular rotates. Word bit 31 is the MSB, as delivered by upstream.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - Once out_valid is high, out_valid and out_r* stay stable until accepted.
  - Register A advances when it is empty or register B will be empty/accepted this cycle.
  - Register B advances when it is empty or out_ready is high.
  - in_ready = !a_valid || a_advance.
  - in_ready never depends combinationally on in_valid.
- Reset (async, any time, including mid-transfer):
  - a_valid = 0, b_valid = 0, so out_valid = 0 and in_ready = 1 after release.
  - out_r* reset to 0.
  - In-flight blocks are dropped.
- Data registers need not be reset, except the out_r* output registers.

## Timing
- Latency: 2 cycles from the accepting edge to out_valid, with no backpressure.
- Throughput: one block per cycle while out_ready stays high.
- Full: both stages hold data and out_ready = 0 → in_ready = 0. No data is lost or duplicated.
- Simultaneous events when full: out_ready rises → in_ready = 1 in that same cycle. The pipeline shifts and accepts a new block on the same edge.
- Empty: bubbles collapse; a lone block still takes exactly 2 cycles.
- out_valid and out_r* come directly from flops.

## Structure
- Shared package `twofish_pkg` holds:
  - Word width constant (32).
  - Rotate functions rol32/ror32.
  - A 128-bit state typedef as four 32-bit words.
  - The PHT function.
- Sub-module: two instances of the existing func_g. No new sub-module.
- Round chaining (16 instances, SWAP=0 on the last) lives in the enclosing core, not here.

## Test plan
- Single block, no backpressure: in_r = {0,0,0,0}, k = {0,0}, s = {0,0}.
  - Required: out_valid exactly 2 cycles after acceptance.
  - Out words match the C golden model: N2 = ROR(F0, 1), N3 = F1, out_r2 = out_r3 = 0.
- Modular wrap: choose k0 = 0xFFFFFFFF with T0 + T1 ≥ 2^32.
  - Required: F0 truncated to 32 bits and matches the model; no carry leaks into other words.
- Streaming with SWAP=0 and SWAP=1: 1000 random blocks, out_ready held high.
  - Required: one output per cycle, in order, bit-exact versus the model for each SWAP setting.
- Backpressure: out_ready = 0 for 5 cycles while in_valid stays high.
  - Required: in_ready drops after 2 accepts; out_r* stable.
  - On release: 2 queued blocks emerge back to back, then streaming resumes; no loss or duplication.
- Simultaneous accept/drain: pipeline full, then out_ready and in_valid both high for one cycle.
  - Required: one output and one input transfer on the same edge.
- Mid-operation reset: assert rst asynchronously with 2 blocks in flight.
  - Required: out_valid = 0 and out_r* = 0 immediately; in_ready = 1 after release.
  - The next block arrives with 2-cycle latency.

Source files
------------

// File: rtl/twofish_pkg.sv
// Shared Twofish round types and helpers.
// Word width, rotates, round state and PHT.
package twofish_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    word_t r0;
    word_t r1;
    word_t r2;
    word_t r3;
  } state_t;

  typedef struct packed {
    word_t w0;
    word_t w1;
  } pht_t;

  function automatic word_t rol32(
    input word_t      x,
    input logic [4:0] n
  );
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic word_t ror32(
    input word_t      x,
    input logic [4:0] n
  );
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  // Pseudo-Hadamard transform: (a+b, a+2b), mod 2^32.
  function automatic pht_t pht(
    input word_t a,
    input word_t b
  );
    pht_t p;
    p.w0 = a + b;
    p.w1 = a + {b[WORD_W-2:0], 1'b0};
    return p;
  endfunction

endpackage

// File: rtl/twofish_round_stage_func_g.sv
// Key-dependent Twofish g function, 128-bit key form.
// Two S-box key words, q-permutations and MDS mix.
module func_g
  import twofish_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] s0,
  input  logic [31:0] s1,
  output logic [31:0] y
);

  localparam logic [3:0] Q0_T0 [16] = '{
    4'h8, 4'h1, 4'h7, 4'hD, 4'h6, 4'hF, 4'h3, 4'h2,
    4'h0, 4'hB, 4'h5, 4'h9, 4'hE, 4'hC, 4'hA, 4'h4};
  localparam logic [3:0] Q0_T1 [16] = '{
    4'hE, 4'hC, 4'hB, 4'h8, 4'h1, 4'h2, 4'h3, 4'h5,
    4'hF, 4'h4, 4'hA, 4'h6, 4'h7, 4'h0, 4'h9, 4'hD};
  localparam logic [3:0] Q0_T2 [16] = '{
    4'hB, 4'hA, 4'h5, 4'hE, 4'h6, 4'hD, 4'h9, 4'h0,
    4'hC, 4'h8, 4'hF, 4'h3, 4'h2, 4'h4, 4'h7, 4'h1};
  localparam logic [3:0] Q0_T3 [16] = '{
    4'hD, 4'h7, 4'hF, 4'h4, 4'h1, 4'h2, 4'h6, 4'hE,
    4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'h5, 4'hC, 4'hA};

  localparam logic [3:0] Q1_T0 [16] = '{
    4'h2, 4'h8, 4'hB, 4'hD, 4'hF, 4'h7, 4'h6, 4'hE,
    4'h3, 4'h1, 4'h9, 4'h4, 4'h0, 4'hA, 4'hC, 4'h5};
  localparam logic [3:0] Q1_T1 [16] = '{
    4'h1, 4'hE, 4'h2, 4'hB, 4'h4, 4'hC, 4'h3, 4'h7,
    4'h6, 4'hD, 4'hA, 4'h5, 4'hF, 4'h9, 4'h0, 4'h8};
  localparam logic [3:0] Q1_T2 [16] = '{
    4'h4, 4'hC, 4'h7, 4'h5, 4'h1, 4'h6, 4'h9, 4'hA,
    4'h0, 4'hE, 4'hD, 4'h8, 4'h2, 4'hB, 4'h3, 4'hF};
  localparam logic [3:0] Q1_T3 [16] = '{
    4'hB, 4'h9, 4'h5, 4'h1, 4'hC, 4'h3, 4'hD, 4'hE,
    4'h6, 4'h4, 4'h7, 4'hF, 4'h2, 4'h0, 4'h8, 4'hA};

  localparam logic [7:0] MDS [4][4] = '{
    '{8'h01, 8'hEF, 8'h5B, 8'h5B},
    '{8'h5B, 8'hEF, 8'hEF, 8'h01},
    '{8'hEF, 8'h5B, 8'h01, 8'hEF},
    '{8'hEF, 8'h01, 8'hEF, 8'h5B}};

  // q-box choice per byte lane (bit i = lane i, 1 = q1)
  localparam logic [3:0] SEL_IN  = 4'b1010;
  localparam logic [3:0] SEL_MID = 4'b1100;
  localparam logic [3:0] SEL_OUT = 4'b0101;

  function automatic logic [3:0] ror4(
    input logic [3:0] v
  );
    return {v[0], v[3:1]};
  endfunction

  function automatic logic [7:0] q_perm(
    input logic       sel,
    input logic [7:0] v
  );
    logic [3:0] a0, b0, a1, b1, a2, b2;
    logic [3:0] a3, b3, a4, b4;
    a0 = v[7:4];
    b0 = v[3:0];
    a1 = a0 ^ b0;
    b1 = a0 ^ ror4(b0) ^ {a0[0], 3'b000};
    a2 = sel ? Q1_T0[a1] : Q0_T0[a1];
    b2 = sel ? Q1_T1[b1] : Q0_T1[b1];
    a3 = a2 ^ b2;
    b3 = a2 ^ ror4(b2) ^ {a2[0], 3'b000};
    a4 = sel ? Q1_T2[a3] : Q0_T2[a3];
    b4 = sel ? Q1_T3[b3] : Q0_T3[b3];
    return {b4, a4};
  endfunction

  // GF(2^8) multiply, field polynomial x^8+x^6+x^5+x^3+1
  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = t[7] ? ({t[6:0], 1'b0} ^ 8'h69)
               : {t[6:0], 1'b0};
    end
    return p;
  endfunction

  logic [3:0][7:0] yb;

  // Keyed q-box chain per byte, then MDS column mix.
  always_comb begin
    yb = '0;
    y  = '0;
    for (int i = 0; i < 4; i++) begin
      yb[i] = q_perm(SEL_OUT[i],
                q_perm(SEL_MID[i],
                  q_perm(SEL_IN[i], x[8*i +: 8])
                  ^ s0[8*i +: 8])
                ^ s1[8*i +: 8]);
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        y[8*i +: 8] = y[8*i +: 8]
                    ^ gf_mul(MDS[i][j], yb[j]);
      end
    end
  end

endmodule

// File: rtl/twofish_round_stage.sv
// Registered Twofish encryption round, two stages.
// g functions into reg A; PHT, keys, rotate/swap into reg B.
module twofish_round_stage
  import twofish_pkg::*;
#(
  parameter logic SWAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_r0,
  input  logic [31:0] in_r1,
  input  logic [31:0] in_r2,
  input  logic [31:0] in_r3,
  input  logic [31:0] in_k0,
  input  logic [31:0] in_k1,
  input  logic [31:0] in_s0,
  input  logic [31:0] in_s1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_r0,
  output logic [31:0] out_r1,
  output logic [31:0] out_r2,
  output logic [31:0] out_r3
);

  logic   a_valid;
  logic   b_valid;
  logic   a_load;
  logic   b_load;
  word_t  r1_rot;
  word_t  g0;
  word_t  g1;
  word_t  a_t0;
  word_t  a_t1;
  word_t  a_k0;
  word_t  a_k1;
  state_t a_st;
  state_t b_st;
  state_t b_nxt;
  pht_t   p;
  word_t  f0;
  word_t  f1;
  word_t  n2;
  word_t  n3;

  assign r1_rot = rol32(in_r1, 5'd8);

  func_g u_g0 (
    .x  (in_r0),
    .s0 (in_s0),
    .s1 (in_s1),
    .y  (g0)
  );

  func_g u_g1 (
    .x  (r1_rot),
    .s0 (in_s0),
    .s1 (in_s1),
    .y  (g1)
  );

  assign b_load   = !b_valid || out_ready;
  assign a_load   = !a_valid || b_load;
  assign in_ready = a_load;

  // Round mix on reg A contents: PHT, subkeys, rotates, swap.
  always_comb begin
    p  = pht(a_t0, a_t1);
    f0 = p.w0 + a_k0;
    f1 = p.w1 + a_k1;
    n2 = ror32(a_st.r2 ^ f0, 5'd1);
    n3 = rol32(a_st.r3, 5'd1) ^ f1;
    if (SWAP) begin
      b_nxt = '{r0: n2, r1: n3,
                r2: a_st.r0, r3: a_st.r1};
    end else begin
      b_nxt = '{r0: a_st.r0, r1: a_st.r1,
                r2: n2, r3: n3};
    end
  end

  // Occupancy flags; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
    end else begin
      if (a_load) a_valid <= in_valid;
      if (b_load) b_valid <= a_valid;
    end
  end

  // Reg A payload: g outputs plus words needed later.
  always_ff @(posedge clk) begin
    if (a_load && in_valid) begin
      a_t0 <= g0;
      a_t1 <= g1;
      a_k0 <= in_k0;
      a_k1 <= in_k1;
      a_st <= '{r0: in_r0, r1: in_r1,
                r2: in_r2, r3: in_r3};
    end
  end

  // Reg B drives the outputs; held while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_st <= '0;
    end else if (b_load && a_valid) begin
      b_st <= b_nxt;
    end
  end

  assign out_valid = b_valid;
  assign out_r0    = b_st.r0;
  assign out_r1    = b_st.r1;
  assign out_r2    = b_st.r2;
  assign out_r3    = b_st.r3;

endmodule

// File: tb/tb_twofish_round_stage.sv
// Bench for twofish_round_stage, both SWAP settings.
// Table vectors, random streams, stalls and reset.
module tb_twofish_round_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_r0 = '0;
  logic [31:0] in_r1 = '0;
  logic [31:0] in_r2 = '0;
  logic [31:0] in_r3 = '0;
  logic [31:0] in_k0 = '0;
  logic [31:0] in_k1 = '0;
  logic [31:0] in_s0 = '0;
  logic [31:0] in_s1 = '0;

  logic        ir_sw, ov_sw, ir_ns, ov_ns;
  logic [31:0] sw0, sw1, sw2, sw3;
  logic [31:0] ns0, ns1, ns2, ns3;
  logic [127:0] out_sw, out_ns;

  assign out_sw = {sw0, sw1, sw2, sw3};
  assign out_ns = {ns0, ns1, ns2, ns3};

  always #5 clk = ~clk;

  twofish_round_stage #(.SWAP(1'b1)) u_sw (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir_sw),
    .in_r0(in_r0), .in_r1(in_r1),
    .in_r2(in_r2), .in_r3(in_r3),
    .in_k0(in_k0), .in_k1(in_k1),
    .in_s0(in_s0), .in_s1(in_s1),
    .out_valid(ov_sw), .out_ready(out_ready),
    .out_r0(sw0), .out_r1(sw1),
    .out_r2(sw2), .out_r3(sw3)
  );

  twofish_round_stage #(.SWAP(1'b0)) u_ns (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir_ns),
    .in_r0(in_r0), .in_r1(in_r1),
    .in_r2(in_r2), .in_r3(in_r3),
    .in_k0(in_k0), .in_k1(in_k1),
    .in_s0(in_s0), .in_s1(in_s1),
    .out_valid(ov_ns), .out_ready(out_ready),
    .out_r0(ns0), .out_r1(ns1),
    .out_r2(ns2), .out_r3(ns3)
  );

  // ---------------- reference model ----------------
  localparam int QT [2][4][16] = '{
    '{'{8,1,7,13,6,15,3,2,0,11,5,9,14,12,10,4},
      '{14,12,11,8,1,2,3,5,15,4,10,6,7,0,9,13},
      '{11,10,5,14,6,13,9,0,12,8,15,3,2,4,7,1},
      '{13,7,15,4,1,2,6,14,9,11,3,0,8,5,12,10}},
    '{'{2,8,11,13,15,7,6,14,3,1,9,4,0,10,12,5},
      '{1,14,2,11,4,12,3,7,6,13,10,5,15,9,0,8},
      '{4,12,7,5,1,6,9,10,0,14,13,8,2,11,3,15},
      '{11,9,5,1,12,3,13,14,6,4,7,15,2,0,8,10}}};

  localparam int MX [4][4] = '{
    '{'h01, 'hEF, 'h5B, 'h5B},
    '{'h5B, 'hEF, 'hEF, 'h01},
    '{'hEF, 'h5B, 'h01, 'hEF},
    '{'hEF, 'h01, 'hEF, 'h5B}};

  function automatic int r4(input int v);
    return (v >> 1) | ((v & 1) << 3);
  endfunction

  function automatic int qp(input int s, input int x);
    int a, b, a1, b1, a2, b2, a3, b3;
    a  = x / 16;
    b  = x % 16;
    a1 = a ^ b;
    b1 = a ^ r4(b) ^ ((8 * a) % 16);
    a2 = QT[s][0][a1];
    b2 = QT[s][1][b1];
    a3 = a2 ^ b2;
    b3 = a2 ^ r4(b2) ^ ((8 * a2) % 16);
    return 16 * QT[s][3][b3] + QT[s][2][a3];
  endfunction

  // carry-less product then reduction by 0x169
  function automatic int gfm(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++)
      if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int i = 14; i >= 8; i--)
      if (((p >> i) & 1) != 0) p = p ^ ('h169 << (i - 8));
    return p;
  endfunction

  function automatic logic [31:0] ref_g(
    input logic [31:0] x, s0, s1
  );
    int l1 [4] = '{0, 1, 0, 1};
    int l2 [4] = '{0, 0, 1, 1};
    int l3 [4] = '{1, 0, 1, 0};
    int yb [4];
    int v, z;
    logic [31:0] g;
    for (int i = 0; i < 4; i++) begin
      v = int'((x >> (8 * i)) & 32'hFF);
      v = qp(l1[i], v) ^ int'((s0 >> (8 * i)) & 32'hFF);
      v = qp(l2[i], v) ^ int'((s1 >> (8 * i)) & 32'hFF);
      yb[i] = qp(l3[i], v);
    end
    g = '0;
    for (int i = 0; i < 4; i++) begin
      z = 0;
      for (int j = 0; j < 4; j++) z = z ^ gfm(MX[i][j], yb[j]);
      g = g | (32'(z) << (8 * i));
    end
    return g;
  endfunction

  function automatic logic [127:0] ref_round(
    input logic [31:0] r0, r1, r2, r3,
    input logic [31:0] k0, k1, s0, s1,
    input logic        swap
  );
    logic [31:0] t0, t1, f0, f1, x2, n2, n3;
    logic [63:0] w0, w1;
    t0 = ref_g(r0, s0, s1);
    t1 = ref_g((r1 << 8) | (r1 >> 24), s0, s1);
    w0 = 64'(t0) + 64'(t1) + 64'(k0);
    w1 = 64'(t0) + 2 * 64'(t1) + 64'(k1);
    f0 = w0[31:0];
    f1 = w1[31:0];
    x2 = r2 ^ f0;
    n2 = (x2 >> 1) | (x2 << 31);
    n3 = ((r3 << 1) | (r3 >> 31)) ^ f1;
    return swap ? {n2, n3, r0, r1} : {r0, r1, n2, n3};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [127:0] e_sw;
    logic [127:0] e_ns;
    int           acc_edge;
  } exp_t;

  typedef struct {
    logic [31:0]  r0, r1, r2, r3;
    logic [31:0]  k0, k1, s0, s1;
    logic [127:0] e_sw;
    logic [127:0] e_ns;
  } vec_t;

  exp_t         sb [$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           ecnt = 0;
  logic         acc_f = 1'b0;
  logic         drn_f = 1'b0;
  logic         stall_prev = 1'b0;
  logic [127:0] prev_sw, prev_ns;
  logic [127:0] cur_sw, cur_ns;

  task automatic chk(
    input string        name,
    input logic [127:0] act,
    input logic [127:0] req
  );
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic set_in(
    input logic        v,
    input logic [31:0] r0, r1, r2, r3,
    input logic [31:0] k0, k1, s0, s1
  );
    in_valid = v;
    in_r0 = r0; in_r1 = r1; in_r2 = r2; in_r3 = r3;
    in_k0 = k0; in_k1 = k1; in_s0 = s0; in_s1 = s1;
    cur_sw = ref_round(r0, r1, r2, r3, k0, k1, s0, s1, 1'b1);
    cur_ns = ref_round(r0, r1, r2, r3, k0, k1, s0, s1, 1'b0);
  endtask

  task automatic set_rand(input logic v);
    set_in(v, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom);
  endtask

  // One cycle: check before the edge, then step to next negedge.
  task automatic tick();
    logic exp_ov, exp_ir;
    #1;
    exp_ov = sb.size() > 0 && ecnt >= sb[0].acc_edge + 1;
    exp_ir = sb.size() < 2 || out_ready;
    chk("out_valid_sw", 128'(ov_sw), 128'(exp_ov));
    chk("out_valid_ns", 128'(ov_ns), 128'(exp_ov));
    chk("in_ready_sw", 128'(ir_sw), 128'(exp_ir));
    chk("in_ready_ns", 128'(ir_ns), 128'(exp_ir));
    if (stall_prev && ov_sw) begin
      chk("hold_sw", out_sw, prev_sw);
      chk("hold_ns", out_ns, prev_ns);
    end
    acc_f = in_valid && exp_ir;
    drn_f = exp_ov && out_ready;
    if (drn_f) begin
      chk("data_sw", out_sw, sb[0].e_sw);
      chk("data_ns", out_ns, sb[0].e_ns);
      void'(sb.pop_front());
    end
    if (acc_f) sb.push_back('{cur_sw, cur_ns, ecnt + 1});
    stall_prev = ov_sw && !out_ready;
    prev_sw = out_sw;
    prev_ns = out_ns;
    @(posedge clk);
    ecnt++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    vec_t        vt [5];
    logic [31:0] wr0, wr1, ws0, ws1;
    logic        found;
    int          n_acc;

    // reset state
    set_in(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(ov_sw | ov_ns), 128'(0));
    chk("rst_out_sw", out_sw, 128'(0));
    chk("rst_out_ns", out_ns, 128'(0));
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 128'(ir_sw & ir_ns), 128'(1));
    @(negedge clk);

    // lone zero block: two register stages of latency
    set_in(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("lat_not_yet", 128'(ov_sw), 128'(0));
    tick();
    #1;
    chk("lat_valid", 128'(ov_sw), 128'(1));
    chk("zero_sw_lo", 128'(out_sw[63:0]), 128'(0));
    chk("zero_ns_hi", 128'(out_ns[127:64]), 128'(0));
    idle(3);

    // pick a wrap vector: T0 + T1 >= 2^32
    found = 1'b0;
    wr0 = '0; wr1 = '0; ws0 = '0; ws1 = '0;
    for (int i = 0; i < 2000 && !found; i++) begin
      wr0 = $urandom; wr1 = $urandom;
      ws0 = $urandom; ws1 = $urandom;
      found = (64'(ref_g(wr0, ws0, ws1))
             + 64'(ref_g((wr1 << 8) | (wr1 >> 24), ws0, ws1)))
             >= 64'h1_0000_0000;
    end

    vt[0] = '{0, 0, 0, 0, 0, 0, 0, 0, '0, '0};
    vt[1] = '{wr0, wr1, 0, 0, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, ws0, ws1, '0, '0};
    vt[2] = '{'1, '1, '1, '1, '1, '1, '1, '1, '0, '0};
    vt[3] = '{32'h0123_4567, 32'h89AB_CDEF,
              32'hFEDC_BA98, 32'h7654_3210,
              32'h1111_1111, 32'h2222_2222,
              32'hA5A5_A5A5, 32'h5A5A_5A5A, '0, '0};
    vt[4] = '{32'h8000_0000, 32'h0000_0001,
              32'h8000_0001, 32'h8000_0000,
              32'h8000_0000, 32'h8000_0000,
              32'h0000_00FF, 32'hFF00_0000, '0, '0};
    foreach (vt[i]) begin
      vt[i].e_sw = ref_round(vt[i].r0, vt[i].r1, vt[i].r2,
                             vt[i].r3, vt[i].k0, vt[i].k1,
                             vt[i].s0, vt[i].s1, 1'b1);
      vt[i].e_ns = ref_round(vt[i].r0, vt[i].r1, vt[i].r2,
                             vt[i].r3, vt[i].k0, vt[i].k1,
                             vt[i].s0, vt[i].s1, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, vt[i].r0, vt[i].r1, vt[i].r2, vt[i].r3,
             vt[i].k0, vt[i].k1, vt[i].s0, vt[i].s1);
      cur_sw = vt[i].e_sw;
      cur_ns = vt[i].e_ns;
      tick();
    end
    idle(3);

    // 1000-block stream, out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      set_rand(1'b1);
      tick();
    end
    idle(3);

    // backpressure: 5 stalled cycles, valid held high
    out_ready = 1'b0;
    n_acc = 0;
    set_rand(1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (in_valid && ir_sw) n_acc++;
      tick();
      if (acc_f) set_rand(1'b1);
    end
    chk("bp_accepts", 128'(n_acc), 128'(2));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (acc_f) set_rand(1'b1);
    end
    idle(3);

    // full pipe, then drain and accept on one edge
    out_ready = 1'b0;
    set_rand(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (acc_f) set_rand(1'b1);
    end
    out_ready = 1'b1;
    #1;
    chk("simul_in", 128'(in_valid && ir_sw), 128'(1));
    chk("simul_out", 128'(ov_sw && out_ready), 128'(1));
    tick();
    out_ready = 1'b0;
    idle(1);
    out_ready = 1'b1;
    idle(3);

    // random handshakes on both sides
    set_rand(1'b1);
    for (int i = 0; i < 300; i++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      tick();
      if (acc_f || !in_valid)
        set_rand(1'($urandom_range(0, 1)));
    end
    out_ready = 1'b1;
    idle(3);

    // asynchronous reset with two blocks in flight
    out_ready = 1'b0;
    set_rand(1'b1);
    tick();
    set_rand(1'b1);
    tick();
    set_in(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(ov_sw | ov_ns), 128'(0));
    chk("mid_rst_sw", out_sw, 128'(0));
    chk("mid_rst_ns", out_ns, 128'(0));
    sb.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    ecnt++;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 128'(ir_sw & ir_ns), 128'(1));
    set_rand(1'b1);
    tick();
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
